// File: rtl/rvc_asap_pkg.sv
// Shared types for the rvc_asap VGA memory path.
//   t_vga_arb_state : arbiter FSM states (idle / VGA burst in flight)
//   t_vga_arb_owner : which requester owns a memory slot
//   VGA_BURST_LEN   : words per scan-line burst (320 px / 32 px-per-word)
//   VGA_ADDR_W      : word address width of the VGA memory
package rvc_asap_pkg;
  typedef enum logic {ARB_IDLE, ARB_VGA_BURST} t_vga_arb_state;
  typedef enum logic {GNT_CORE, GNT_VGA} t_vga_arb_owner;
  localparam int VGA_BURST_LEN = 10;
  localparam int VGA_ADDR_W    = 14;
endpackage

// File: rtl/rvc_asap_rr_arb2.sv
// Two-way round-robin grant with a LastGrant flop.
//   clk, rst            : clock, async active-high reset
//   en                  : arbitration allowed this cycle (transfer boundary)
//   req_core, req_vga   : requests
//   gnt_core, gnt_vga   : one-hot (or zero) grants, combinational
// On a tie the grant goes to whoever did not win last. Reset leaves
// LastGrant = CORE, so the VGA side wins the first tie.
module rvc_asap_rr_arb2
  import rvc_asap_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_core,
  input  logic req_vga,
  output logic gnt_core,
  output logic gnt_vga
);

  t_vga_arb_owner last_q, last_d;

  always_comb begin
    gnt_core = 1'b0;
    gnt_vga  = 1'b0;
    if (en) begin
      if (req_core && req_vga) begin
        gnt_vga  = (last_q == GNT_CORE);
        gnt_core = (last_q == GNT_VGA);
      end else begin
        gnt_core = req_core;
        gnt_vga  = req_vga;
      end
    end
    last_d = last_q;
    if (gnt_core)     last_d = GNT_CORE;
    else if (gnt_vga) last_d = GNT_VGA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= GNT_CORE;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/rvc_asap_5pl_vga_mem_arb.sv
// Arbiter sharing the single-port VGA memory between the core load/store
// port (single beats) and the VGA scan-out fetcher (BURST_LEN-word bursts).
//   Clock, Rst          : clock, async active-high reset
//   CoreReq* / CoreRsp* : core request (ready same cycle) and read response
//   VgaReq*  / VgaRsp*  : burst request and per-beat read responses
//   Mem*                : memory strobe/address/data, MemRdData 1 cycle later
//   CoreStallCnt        : saturating count of cycles the core was held off
// Arbitration happens only in ARB_IDLE; once a burst starts it runs for
// BURST_LEN consecutive cycles and cannot be preempted.
module rvc_asap_5pl_vga_mem_arb
  import rvc_asap_pkg::*;
#(
  parameter int ADDR_W      = VGA_ADDR_W,
  parameter int BURST_LEN   = VGA_BURST_LEN,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clock,
  input  logic                   Rst,
  input  logic                   CoreReqValid,
  input  logic                   CoreReqWr,
  input  logic [ADDR_W-1:0]      CoreReqAddr,
  input  logic [31:0]            CoreReqWrData,
  input  logic [3:0]             CoreReqByteEn,
  output logic                   CoreReqReady,
  output logic                   CoreRspValid,
  output logic [31:0]            CoreRspData,
  input  logic                   VgaReqValid,
  input  logic [ADDR_W-1:0]      VgaReqAddr,
  output logic                   VgaReqReady,
  output logic                   VgaRspValid,
  output logic [31:0]            VgaRspData,
  output logic                   VgaRspLast,
  output logic                   MemEn,
  output logic                   MemWr,
  output logic [ADDR_W-1:0]      MemAddr,
  output logic [31:0]            MemWrData,
  output logic [3:0]             MemByteEn,
  input  logic [31:0]            MemRdData,
  output logic [STALL_CNT_W-1:0] CoreStallCnt
);

  localparam int CNT_W = $clog2(BURST_LEN);

  t_vga_arb_state         state_q, state_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   rsp_core_q, rsp_core_d;
  logic                   rsp_vga_q, rsp_vga_d;
  logic                   rsp_last_q, rsp_last_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   gnt_core, gnt_vga;

  // Rst gates the grant so combinational outputs drop with the reset edge,
  // not one clock later.
  rvc_asap_rr_arb2 u_rr (
    .clk      (Clock),
    .rst      (Rst),
    .en       ((state_q == ARB_IDLE) && !Rst),
    .req_core (CoreReqValid),
    .req_vga  (VgaReqValid),
    .gnt_core (gnt_core),
    .gnt_vga  (gnt_vga)
  );

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    addr_d       = addr_q;
    rsp_core_d   = 1'b0;
    rsp_vga_d    = 1'b0;
    rsp_last_d   = 1'b0;
    CoreReqReady = 1'b0;
    VgaReqReady  = 1'b0;
    MemEn        = 1'b0;
    MemWr        = 1'b0;
    MemAddr      = '0;
    MemWrData    = '0;
    MemByteEn    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_core) begin
          CoreReqReady = 1'b1;
          MemEn        = 1'b1;
          MemWr        = CoreReqWr;
          MemAddr      = CoreReqAddr;
          MemWrData    = CoreReqWrData;
          MemByteEn    = CoreReqByteEn;
          rsp_core_d   = !CoreReqWr;
        end else if (gnt_vga) begin
          // Beat 0 goes out in the grant cycle; BURST_LEN >= 2 so it is never last.
          VgaReqReady  = 1'b1;
          MemEn        = 1'b1;
          MemAddr      = VgaReqAddr;
          addr_d       = VgaReqAddr + ADDR_W'(1);
          beat_cnt_d   = CNT_W'(1);
          rsp_vga_d    = 1'b1;
          state_d      = ARB_VGA_BURST;
        end
      end
      ARB_VGA_BURST: begin
        MemEn      = 1'b1;
        MemAddr    = addr_q;
        addr_d     = addr_q + ADDR_W'(1);
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        rsp_vga_d  = 1'b1;
        if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
          rsp_last_d = 1'b1;
          beat_cnt_d = '0;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    stall_d = stall_q;
    if (CoreReqValid && !CoreReqReady && (stall_q != {STALL_CNT_W{1'b1}}))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q    <= ARB_IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      rsp_core_q <= 1'b0;
      rsp_vga_q  <= 1'b0;
      rsp_last_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      rsp_core_q <= rsp_core_d;
      rsp_vga_q  <= rsp_vga_d;
      rsp_last_q <= rsp_last_d;
      stall_q    <= stall_d;
    end
  end

  assign CoreRspValid = rsp_core_q;
  assign CoreRspData  = rsp_core_q ? MemRdData : 32'h0;
  assign VgaRspValid  = rsp_vga_q;
  assign VgaRspData   = rsp_vga_q ? MemRdData : 32'h0;
  assign VgaRspLast   = rsp_last_q;
  assign CoreStallCnt = stall_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_mem_arb.sv
module tb_rvc_asap_5pl_vga_mem_arb;
  localparam int AW   = 14;
  localparam int BL   = 10;
  localparam int SCW  = 6;
  localparam int ASZ  = 1 << AW;
  localparam int SMAX = (1 << SCW) - 1;

  logic           Clock = 1'b0;
  logic           Rst = 1'b1;
  logic           CoreReqValid = 1'b0, CoreReqWr = 1'b0;
  logic [AW-1:0]  CoreReqAddr = '0;
  logic [31:0]    CoreReqWrData = '0;
  logic [3:0]     CoreReqByteEn = '0;
  logic           CoreReqReady, CoreRspValid;
  logic [31:0]    CoreRspData;
  logic           VgaReqValid = 1'b0;
  logic [AW-1:0]  VgaReqAddr = '0;
  logic           VgaReqReady, VgaRspValid, VgaRspLast;
  logic [31:0]    VgaRspData;
  logic           MemEn, MemWr;
  logic [AW-1:0]  MemAddr;
  logic [31:0]    MemWrData;
  logic [3:0]     MemByteEn;
  logic [31:0]    MemRdData = '0;
  logic [SCW-1:0] CoreStallCnt;

  rvc_asap_5pl_vga_mem_arb #(.ADDR_W(AW), .BURST_LEN(BL), .STALL_CNT_W(SCW)) dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReqValid(CoreReqValid), .CoreReqWr(CoreReqWr), .CoreReqAddr(CoreReqAddr),
    .CoreReqWrData(CoreReqWrData), .CoreReqByteEn(CoreReqByteEn), .CoreReqReady(CoreReqReady),
    .CoreRspValid(CoreRspValid), .CoreRspData(CoreRspData),
    .VgaReqValid(VgaReqValid), .VgaReqAddr(VgaReqAddr), .VgaReqReady(VgaReqReady),
    .VgaRspValid(VgaRspValid), .VgaRspData(VgaRspData), .VgaRspLast(VgaRspLast),
    .MemEn(MemEn), .MemWr(MemWr), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemByteEn(MemByteEn), .MemRdData(MemRdData), .CoreStallCnt(CoreStallCnt)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  // Memory seen by the DUT (driven from its actual Mem* outputs) and the
  // reference copy updated only from expected transfers.
  logic [31:0] env_mem [ASZ];
  logic [31:0] ref_mem [ASZ];
  bit          rd_pend;
  logic [AW-1:0] rd_addr;

  // Pending requests (held stable until accepted)
  bit            c_pend, c_wr;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wd;
  logic [3:0]    c_be;
  bit            v_pend;
  logic [AW-1:0] v_addr;

  // Reference model: beats still owed to the running burst, next burst
  // address, who won the last tie, stall count, response due next cycle.
  int          m_rem, m_addr, m_stall;
  bit          m_last_vga;
  bit          m_pc, m_pv, m_pl;
  logic [31:0] m_pd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic tick(input bit r);
    bit e_cr, e_vr, e_en, e_wr, e_last, vbeat;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;
    logic [3:0]    e_be;
    Rst = r;
    CoreReqValid = c_pend; CoreReqWr = c_wr; CoreReqAddr = c_addr;
    CoreReqWrData = c_wd; CoreReqByteEn = c_be;
    VgaReqValid = v_pend; VgaReqAddr = v_addr;
    e_cr = 0; e_vr = 0; e_en = 0; e_wr = 0; e_last = 0; vbeat = 0;
    e_addr = '0; e_wd = '0; e_be = '0;
    if (!r) begin
      if (m_rem > 0) begin
        e_en = 1; e_addr = AW'(m_addr); vbeat = 1; e_last = (m_rem == 1);
        m_addr = (m_addr + 1) % ASZ; m_rem--;
      end else if (c_pend && (!v_pend || m_last_vga)) begin
        e_cr = 1; e_en = 1; e_wr = c_wr; e_addr = c_addr; e_wd = c_wd; e_be = c_be;
        m_last_vga = 0;
      end else if (v_pend) begin
        e_vr = 1; e_en = 1; e_addr = v_addr; vbeat = 1;
        m_addr = (int'(v_addr) + 1) % ASZ; m_rem = BL - 1; m_last_vga = 1;
      end
    end
    @(negedge Clock);
    chk("core_ready", CoreReqReady, e_cr);
    chk("vga_ready",  VgaReqReady,  e_vr);
    chk("mem_en",     MemEn,        e_en);
    chk("mem_wr",     MemWr,        e_wr);
    chk("mem_addr",   MemAddr,      e_addr);
    chk("mem_wdata",  MemWrData,    e_wd);
    chk("mem_be",     MemByteEn,    e_be);
    chk("core_rsp_v", CoreRspValid, r ? 1'b0 : m_pc);
    chk("core_rsp_d", CoreRspData,  (!r && m_pc) ? m_pd : 32'h0);
    chk("vga_rsp_v",  VgaRspValid,  r ? 1'b0 : m_pv);
    chk("vga_rsp_d",  VgaRspData,   (!r && m_pv) ? m_pd : 32'h0);
    chk("vga_last",   VgaRspLast,   r ? 1'b0 : m_pl);
    chk("stall_cnt",  CoreStallCnt, r ? 0 : m_stall);
    if (r) begin
      m_rem = 0; m_last_vga = 0; m_stall = 0; m_pc = 0; m_pv = 0; m_pl = 0; m_pd = '0;
    end else begin
      if (c_pend && !e_cr) m_stall = (m_stall == SMAX) ? SMAX : m_stall + 1;
      m_pc = e_cr && !e_wr;
      m_pv = vbeat;
      m_pl = e_last;
      m_pd = (e_en && !e_wr) ? ref_mem[e_addr] : 32'h0;
      if (e_en && e_wr) ref_mem[e_addr] = merge(ref_mem[e_addr], e_wd, e_be);
      if (e_cr) c_pend = 0;
      if (e_vr) v_pend = 0;
    end
    rd_pend = MemEn && !MemWr;
    rd_addr = MemAddr;
    if (MemEn && MemWr) env_mem[MemAddr] = merge(env_mem[MemAddr], MemWrData, MemByteEn);
    @(posedge Clock);
    #1;
    MemRdData = rd_pend ? env_mem[rd_addr] : $urandom();
  endtask

  task automatic mk_core(input bit wr);
    c_pend = 1; c_wr = wr;
    c_addr = AW'($urandom_range(63));
    c_wd = $urandom(); c_be = 4'($urandom_range(15));
  endtask

  task automatic mk_vga();
    v_pend = 1;
    v_addr = AW'($urandom_range(ASZ - 1));
  endtask

  task automatic run(input int n, input int pc, input int pv);
    repeat (n) begin
      if (!c_pend && $urandom_range(99) < pc) mk_core(1'($urandom_range(1)));
      if (!v_pend && $urandom_range(99) < pv) mk_vga();
      tick(0);
    end
  endtask

  initial begin
    for (int i = 0; i < ASZ; i++) begin
      env_mem[i] = $urandom();
      ref_mem[i] = env_mem[i];
    end
    c_pend = 0; c_wr = 0; c_addr = '0; c_wd = '0; c_be = '0;
    v_pend = 0; v_addr = '0;
    m_rem = 0; m_addr = 0; m_stall = 0; m_last_vga = 0;
    m_pc = 0; m_pv = 0; m_pl = 0; m_pd = '0;
    rd_pend = 0; rd_addr = '0;

    tick(1);
    tick(1);

    // Both valid straight out of reset: VGA first, core waits 10 cycles
    c_pend = 1; c_wr = 0; c_addr = 14'h020; c_wd = '0; c_be = 4'hF;
    v_pend = 1; v_addr = 14'h200;
    repeat (11) tick(0);
    chk("t3_stall_total", CoreStallCnt, 10);
    tick(0);

    // Core write then read-back
    c_pend = 1; c_wr = 1; c_addr = 14'h010; c_wd = 32'hDEADBEEF; c_be = 4'hF;
    tick(0);
    c_pend = 1; c_wr = 0; c_addr = 14'h010; c_wd = '0; c_be = 4'hF;
    tick(0);
    #1;
    chk("t1_rdata", CoreRspData, 32'hDEADBEEF);
    tick(0);

    // VGA-only burst, then one that wraps the address space
    v_pend = 1; v_addr = 14'h100;
    repeat (11) tick(0);
    v_pend = 1; v_addr = 14'h3FFA;
    repeat (11) tick(0);

    // Both continuously valid: burst / core / burst / core with no gaps
    repeat (44) begin
      if (!c_pend) mk_core(1'($urandom_range(1)));
      if (!v_pend) mk_vga();
      tick(0);
    end
    c_pend = 0; v_pend = 0;
    repeat (12) tick(0);

    run(300, 40, 15);
    run(200, 80, 50);
    c_pend = 0; v_pend = 0;
    repeat (12) tick(0);

    // Reset in the beat-4 cycle of a burst, then a tie goes to VGA again
    v_pend = 1; v_addr = 14'h150;
    repeat (4) tick(0);
    tick(1);
    mk_core(0);
    v_pend = 1; v_addr = 14'h050;
    tick(0);
    repeat (11) tick(0);

    // Stall counter saturation
    repeat (90) begin
      if (!c_pend) mk_core(1'($urandom_range(1)));
      if (!v_pend) mk_vga();
      tick(0);
    end
    chk("stall_saturated", CoreStallCnt, SMAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
